// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and byte-lane helpers for the SRAM controller.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        ERR_OKAY = 2'd0,
        ERR_ERR1 = 2'd1,
        ERR_ERR2 = 2'd2
    } err_state_e;

    // Byte lanes touched by a transfer; oversize transfers act as words.
    function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << off;
            HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    // Misaligned or unsupported transfer size.
    function automatic logic bad_xfer(input logic [2:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = off[0];
            HSIZE_WORD: bad = (off != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry write buffer: parks a write displaced by a read, commits it
// when the SRAM port is free, and forwards its bytes into read data.
module ahb_sram_wbuf
    import ahb_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture_i,
    input  logic          commit_i,
    input  logic [AW-1:0] cap_addr_i,
    input  logic [3:0]    cap_be_i,
    input  logic [31:0]   cap_data_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [31:0]   sram_rdata_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic [3:0]    be_o,
    output logic [31:0]   data_o,
    output logic [31:0]   rdata_merged_c_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   data_q, data_d;
    logic          hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        be_d    = be_q;
        data_d  = data_q;
        if (capture_i) begin
            valid_d = 1'b1;
            addr_d  = cap_addr_i;
            be_d    = cap_be_i;
            data_d  = cap_data_i;
        end else if (commit_i) begin
            valid_d = 1'b0;
        end
    end

    // Per-lane forwarding of buffered bytes over stale SRAM data.
    assign hit = valid_q & (addr_q == rd_addr_i);

    always_comb begin
        rdata_merged_c_o = sram_rdata_i;
        for (int i = 0; i < 4; i++) begin
            if (hit && be_q[i]) begin
                rdata_merged_c_o[8*i +: 8] = data_q[8*i +: 8];
            end
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign be_o    = be_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ahb_sram_ctrl.sv
// Zero-wait-state AHB-Lite slave for a 1-cycle synchronous SRAM.
// Define AHB_SRAM_ERR_EN to return ERROR for misaligned/oversize transfers.
module ahb_sram_ctrl
    import ahb_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          sram_cs,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    logic          acc, misalign, rd_ap, wr_dp, rd_dp;
    logic          capture, commit;
    logic          dp_valid_q, dp_valid_d;
    logic          dp_write_q, dp_write_d;
    logic [AW-1:0] dp_addr_q, dp_addr_d;
    logic [3:0]    dp_be_q, dp_be_d;
    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [3:0]    buf_be;
    logic [31:0]   buf_data;
    logic [31:0]   rdata_merged;
    logic          unused_bits;

    assign acc = HSEL & HTRANS[1] & HREADY;

`ifdef AHB_SRAM_ERR_EN
    logic       err_ap;
    err_state_e state_q, state_d;
    logic       hreadyout_c, hresp_c;

    assign misalign = bad_xfer(HSIZE, HADDR[1:0]);
    assign err_ap   = acc & misalign;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ERR_OKAY;
        else          state_q <= state_d;
    end

    // Two-cycle ERROR response; a new error may start in ERR2.
    always_comb begin
        state_d     = state_q;
        hreadyout_c = 1'b1;
        hresp_c     = HRESP_OKAY;
        case (state_q)
            ERR_OKAY: if (err_ap) state_d = ERR_ERR1;
            ERR_ERR1: begin
                hreadyout_c = 1'b0;
                hresp_c     = HRESP_ERROR;
                state_d     = ERR_ERR2;
            end
            ERR_ERR2: begin
                hresp_c = HRESP_ERROR;
                state_d = err_ap ? ERR_ERR1 : ERR_OKAY;
            end
            default:  state_d = ERR_OKAY;
        endcase
    end

    assign HREADYOUT = hreadyout_c;
    assign HRESP     = hresp_c;
`else
    assign misalign  = 1'b0;
    assign HREADYOUT = 1'b1;
    assign HRESP     = HRESP_OKAY;
`endif

    assign rd_ap = acc & ~misalign & ~HWRITE;
    assign wr_dp = dp_valid_q & dp_write_q;
    assign rd_dp = dp_valid_q & ~dp_write_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_be_q    <= '0;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            dp_be_q    <= dp_be_d;
        end
    end

    always_comb begin
        dp_valid_d = acc & ~misalign;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        dp_be_d    = dp_be_q;
        if (acc) begin
            dp_write_d = HWRITE;
            dp_addr_d  = HADDR[AW+1:2];
            dp_be_d    = be_from_size(HSIZE, HADDR[1:0]);
        end
    end

    // Port arbitration: read address phase, then direct write, then commit.
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        capture    = 1'b0;
        commit     = 1'b0;
        if (rd_ap) begin
            sram_cs   = 1'b1;
            sram_addr = HADDR[AW+1:2];
            capture   = wr_dp;
        end else if (wr_dp) begin
            sram_cs    = 1'b1;
            sram_we    = dp_be_q;
            sram_addr  = dp_addr_q;
            sram_wdata = HWDATA;
        end else if (buf_valid) begin
            sram_cs    = 1'b1;
            sram_we    = buf_be;
            sram_addr  = buf_addr;
            sram_wdata = buf_data;
            commit     = 1'b1;
        end
    end

    ahb_sram_wbuf #(.AW(AW)) u_wbuf (
        .clk              (HCLK),
        .rst_n            (HRESETn),
        .capture_i        (capture),
        .commit_i         (commit),
        .cap_addr_i       (dp_addr_q),
        .cap_be_i         (dp_be_q),
        .cap_data_i       (HWDATA),
        .rd_addr_i        (dp_addr_q),
        .sram_rdata_i     (sram_rdata),
        .valid_o          (buf_valid),
        .addr_o           (buf_addr),
        .be_o             (buf_be),
        .data_o           (buf_data),
        .rdata_merged_c_o (rdata_merged)
    );

    assign HRDATA = rd_dp ? rdata_merged : 32'h0;

    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Scoreboard bench for ahb_sram_ctrl with a behavioural 1-cycle SRAM.
module tb_ahb_sram_ctrl;
    import ahb_pkg::*;

    localparam int unsigned AW = 10;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic          sram_cs;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [31:0]   exp_mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    logic [31:0]   sb_q [$];
    logic          rd_pend;
    logic [31:0]   wdata_pend;
    logic          s_cs, s_ready, s_resp;
    logic [3:0]    s_we;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    int            n_checks;
    int            n_fail;

    always #5 HCLK = ~HCLK;

    assign HREADY = HREADYOUT;

    ahb_sram_ctrl #(.AW(AW)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HWRITE     (HWRITE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Synchronous SRAM model with a bench-side preload port.
    always @(posedge HCLK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (sram_cs) begin
            if (sram_we == 4'b0000) sram_rdata <= mem[sram_addr];
            for (int i = 0; i < 4; i++)
                if (sram_we[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
    end

    function automatic logic [3:0] tb_be(input logic [2:0] size, input logic [1:0] off);
        if (size == 3'd0) return 4'b0001 << off;
        if (size == 3'd1) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic tb_bad(input logic [2:0] size, input logic [1:0] off);
`ifdef AHB_SRAM_ERR_EN
        if (size == 3'd1) return off[0];
        if (size == 3'd2) return off != 2'b00;
        return size >= 3'd3;
`else
        return 1'b0;
`endif
    endfunction

    task automatic preload(input logic [AW-1:0] wa, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = wa; pl_data = d;
        exp_mem[wa] = d;
        @(posedge HCLK); #1;
        pl_en = 1'b0;
    endtask

    // One bus cycle: drive an address phase, sample at negedge, end after the edge.
    task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] data);
        logic          act;
        logic [3:0]    be;
        logic [AW-1:0] wa;
        HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
        HWDATA = wdata_pend;
        act = sel & trans[1] & HREADY & ~tb_bad(size, addr[1:0]);
        wa  = addr[AW+1:2];
        if (act && wr) begin
            be = tb_be(size, addr[1:0]);
            for (int i = 0; i < 4; i++)
                if (be[i]) exp_mem[wa][8*i +: 8] = data[8*i +: 8];
        end
        if (act && !wr) sb_q.push_back(exp_mem[wa]);
        @(negedge HCLK);
        s_cs = sram_cs; s_we = sram_we; s_addr = sram_addr; s_wdata = sram_wdata;
        s_ready = HREADYOUT; s_resp = HRESP;
        @(posedge HCLK); #1;
        rd_pend    = act & ~wr;
        wdata_pend = (act && wr) ? data : 32'h0;
    endtask

    task automatic idle();
        issue(1'b0, HTRANS_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    endtask

    // Read data scoreboard plus the empty-buffer-at-write-data-phase invariant.
    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge HCLK);
            if (HRESETn) begin
                if (dut.dp_valid_q && dut.dp_write_q) begin
                    n_checks++;
                    if (dut.u_wbuf.valid_q !== 1'b0) begin
                        n_fail++;
                        $display("FAIL wbuf_empty_at_wdata: buf_valid=%b required 0 t=%0t", dut.u_wbuf.valid_q, $time);
                    end
                end
                if (rd_pend) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_underflow: read data phase with empty scoreboard t=%0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        if (HRDATA !== e) begin
                            n_fail++;
                            $display("FAIL hrdata: got %h required %h t=%0t", HRDATA, e, $time);
                        end
                    end
                    n_checks++;
                    if (HREADYOUT !== 1'b1) begin
                        n_fail++;
                        $display("FAIL zero_wait: HREADYOUT=%b required 1 t=%0t", HREADYOUT, $time);
                    end
                end else begin
                    n_checks++;
                    if (HRDATA !== 32'h0) begin
                        n_fail++;
                        $display("FAIL hrdata_idle: got %h required 0 t=%0t", HRDATA, $time);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        n_checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: rdy=%b resp=%b rdata=%h required 1 0 0", HREADYOUT, HRESP, HRDATA);
        end
        n_checks++;
        if (sram_cs !== 1'b0 || sram_we !== 4'h0 || dut.u_wbuf.valid_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sram: cs=%b we=%h buf=%b required 0 0 0", sram_cs, sram_we, dut.u_wbuf.valid_q);
        end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
    endtask

    task automatic test_word_rw();
        issue(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h010, 32'hDEADBEEF);
        idle();
        n_checks++;
        if (s_cs !== 1'b1 || s_we !== 4'hF || s_addr !== AW'(4) || s_wdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_wr: cs=%b we=%h addr=%h wdata=%h required 1 f 004 deadbeef", s_cs, s_we, s_addr, s_wdata);
        end
        issue(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h010, 32'h0);
        idle();
    endtask

    task automatic test_byte_write();
        preload(AW'(4), 32'h11223344);
        issue(1'b1, HTRANS_NONSEQ, 1'b1, 3'd0, 32'h013, 32'hAB000000);
        idle();
        n_checks++;
        if (s_we !== 4'b1000) begin
            n_fail++;
            $display("FAIL byte_we: got %b required 1000", s_we);
        end
        issue(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h010, 32'h0);
        idle();
    endtask

    task automatic test_forward_word();
        issue(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h020, 32'hCAFEF00D);
        issue(1'b1, HTRANS_SEQ, 1'b0, 3'd2, 32'h020, 32'h0);
        n_checks++;
        if (s_cs !== 1'b1 || s_we !== 4'h0 || s_addr !== AW'(8)) begin
            n_fail++;
            $display("FAIL fwd_read_port: cs=%b we=%h addr=%h required 1 0 008", s_cs, s_we, s_addr);
        end
        idle();
        n_checks++;
        if (s_cs !== 1'b1 || s_we !== 4'hF || s_addr !== AW'(8) || s_wdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL fwd_commit: cs=%b we=%h addr=%h wdata=%h required 1 f 008 cafef00d", s_cs, s_we, s_addr, s_wdata);
        end
        idle();
        n_checks++;
        if (mem[8] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL fwd_mem: got %h required cafef00d", mem[8]);
        end
    endtask

    task automatic test_forward_half();
        preload(AW'(12), 32'hAAAABBBB);
        issue(1'b1, HTRANS_NONSEQ, 1'b1, 3'd1, 32'h032, 32'h55660000);
        issue(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h030, 32'h0);
        idle();
        n_checks++;
        if (s_we !== 4'b1100 || s_addr !== AW'(12)) begin
            n_fail++;
            $display("FAIL half_commit: we=%b addr=%h required 1100 00c", s_we, s_addr);
        end
        issue(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h030, 32'h0);
        idle();
    endtask

    task automatic test_reset_mid();
        issue(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h020, 32'h12345678);
        issue(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h020, 32'h0);
        HRESETn = 1'b0;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        rd_pend = 1'b0; wdata_pend = 32'h0;
        sb_q.delete();
        exp_mem[8] = 32'hCAFEF00D;
        #1;
        n_checks++;
        if (dut.u_wbuf.valid_q !== 1'b0 || sram_we !== 4'h0 || HREADYOUT !== 1'b1 || HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: buf=%b we=%h rdy=%b rdata=%h required 0 0 1 0",
                     dut.u_wbuf.valid_q, sram_we, HREADYOUT, HRDATA);
        end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        idle();
        n_checks++;
        if (mem[8] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL reset_mid_mem: got %h required cafef00d", mem[8]);
        end
        issue(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h020, 32'h0);
        idle();
    endtask

    task automatic test_back_to_back();
        issue(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h040, 32'h00000001);
        issue(1'b1, HTRANS_SEQ,    1'b1, 3'd2, 32'h044, 32'h00000002);
        n_checks++;
        if (s_we !== 4'hF || s_addr !== AW'(16) || s_wdata !== 32'h1) begin
            n_fail++;
            $display("FAIL b2b_first: we=%h addr=%h wdata=%h required f 010 1", s_we, s_addr, s_wdata);
        end
        idle();
        n_checks++;
        if (s_we !== 4'hF || s_addr !== AW'(17) || s_wdata !== 32'h2) begin
            n_fail++;
            $display("FAIL b2b_second: we=%h addr=%h wdata=%h required f 011 2", s_we, s_addr, s_wdata);
        end
        issue(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h040, 32'h0);
        issue(1'b1, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h044, 32'h00000003);
        issue(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h044, 32'h0);
        idle();
        n_checks++;
        if (s_we !== 4'hF || s_addr !== AW'(17) || s_wdata !== 32'h3) begin
            n_fail++;
            $display("FAIL rwr_commit: we=%h addr=%h wdata=%h required f 011 3", s_we, s_addr, s_wdata);
        end
    endtask

    task automatic test_idle_nosel();
        preload(AW'(20), 32'h0BADF00D);
        issue(1'b0, HTRANS_NONSEQ, 1'b1, 3'd2, 32'h050, 32'h11111111);
        n_checks++;
        if (s_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL nosel_cs: got %b required 0", s_cs);
        end
        issue(1'b1, HTRANS_BUSY, 1'b1, 3'd2, 32'h050, 32'h22222222);
        n_checks++;
        if (s_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_cs: got %b required 0", s_cs);
        end
        idle();
        n_checks++;
        if (s_cs !== 1'b0 || mem[20] !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL idle_mem: cs=%b mem=%h required 0 0badf00d", s_cs, mem[20]);
        end
    endtask

    task automatic test_misaligned();
        issue(1'b1, HTRANS_NONSEQ, 1'b0, 3'd2, 32'h021, 32'h0);
`ifdef AHB_SRAM_ERR_EN
        n_checks++;
        if (s_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cs: got %b required 0", s_cs);
        end
        idle();
        n_checks++;
        if (s_ready !== 1'b0 || s_resp !== 1'b1 || s_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cycle1: rdy=%b resp=%b cs=%b required 0 1 0", s_ready, s_resp, s_cs);
        end
        idle();
        n_checks++;
        if (s_ready !== 1'b1 || s_resp !== 1'b1 || s_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cycle2: rdy=%b resp=%b cs=%b required 1 1 0", s_ready, s_resp, s_cs);
        end
        idle();
        n_checks++;
        if (s_ready !== 1'b1 || s_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL err_done: rdy=%b resp=%b required 1 0", s_ready, s_resp);
        end
`else
        n_checks++;
        if (s_cs !== 1'b1 || s_addr !== AW'(8)) begin
            n_fail++;
            $display("FAIL unaligned_port: cs=%b addr=%h required 1 008", s_cs, s_addr);
        end
        idle();
        n_checks++;
        if (s_ready !== 1'b1 || s_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL unaligned_okay: rdy=%b resp=%b required 1 0", s_ready, s_resp);
        end
`endif
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rd_pend = 1'b0; wdata_pend = 32'h0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        HSEL = 1'b0; HADDR = 32'h0; HTRANS = HTRANS_IDLE; HSIZE = 3'd2;
        HWRITE = 1'b0; HWDATA = 32'h0;
        for (int i = 0; i < (1 << AW); i++) exp_mem[i] = 32'h0;
        fork
            monitor();
        join_none
        test_reset();
        test_word_rw();
        test_byte_write();
        test_forward_word();
        test_forward_half();
        test_reset_mid();
        test_back_to_back();
        test_idle_nosel();
        test_misaligned();
        idle();
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

endmodule

// File: doc/ahb_sram_ctrl.md
Name: ahb_sram_ctrl

Overview:
Zero-wait-state AHB-Lite slave that sits directly downstream of the core's AHB-Lite master port and drives a single-port synchronous SRAM (1-cycle read latency). Reads are issued in the address phase. Write data from the data phase goes straight to SRAM, or is parked in a one-entry write buffer when a read address phase needs the port in the same cycle. Buffered bytes are forwarded on read hits.

Parameters:
AW, 10, SRAM word-address width (depth = 2^AW 32-bit words; 4 KB default)

Ports:
HCLK  in  1  system clock
HRESETn  in  1  reset, asynchronous, active-low
HSEL  in  1  slave select from decoder
HADDR  in  32  transfer address; HADDR[AW+1:2] used
HTRANS  in  2  transfer type; only NONSEQ(10)/SEQ(11) are active
HSIZE  in  3  0=byte, 1=half, 2=word
HWRITE  in  1  1=write
HWDATA  in  32  write data, valid in data phase
HREADY  in  1  bus ready (previous transfer complete)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  32  read data
sram_cs  out  1  SRAM chip select
sram_we  out  4  per-byte write enable (0 = read when cs=1)
sram_addr  out  AW  SRAM word address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid the cycle after a read

Behaviour:
- Address phase accepted when HSEL & HTRANS[1] & HREADY. Registered at the HCLK edge: word address, byte enables, write flag, valid.
- Byte enables by size:
  - HSIZE=0: 4'b0001<<HADDR[1:0]
  - HSIZE=1: HADDR[1] ? 4'b1100 : 4'b0011
  - HSIZE=2: 4'b1111
- SRAM port priority per cycle, highest first:
  - (1) Read address phase: cs=1, we=0, addr=HADDR[AW+1:2], combinational.
  - (2) Write data phase with no concurrent read address phase: cs=1, we=registered BE, wdata=HWDATA (direct write).
  - (3) Write buffer commit: cs=1, we=buf_be, wdata=buf_data; buf_valid cleared at the edge.
  - Otherwise cs=0, we=0.
- Write data phase with a concurrent read address phase: HWDATA, addr and BE are captured into the buffer and buf_valid is set.
- Invariant: the buffer is always empty at any write data phase. The preceding write address phase cycle always frees the port for a commit. Asserted in the bench.
- Read data phase: HRDATA = sram_rdata, with each byte lane replaced by buf_data where buf_valid & buf_be[i] & buf_addr==read addr. Merge uses the buffer state in the data-phase cycle.
- Latency: reads and writes complete with zero wait states; HREADYOUT=1 outside error responses.
- Outside a read data phase: HRDATA=0.
- HTRANS IDLE/BUSY or HSEL=0: no SRAM access and no state change, except a pending buffer commit.
- Back-to-back writes: each data phase writes directly.
- W→R to the same word: the read sees the new bytes via forwarding.
- R→W→R sequences are fully pipelined.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, sram_cs=0, sram_we=0, buf_valid=0, all phase registers cleared.
- Reset asserted mid-operation: any buffered write is discarded and any in-flight transfer is abandoned.
- Upper HADDR bits above AW+1 are ignored; range decoding belongs to the decoder.

Optional Feature:
AHB_SRAM_ERR_EN
- Defined: misaligned transfers (HSIZE=1 with HADDR[0]=1; HSIZE=2 with HADDR[1:0]!=0) and HSIZE>=3 perform no SRAM access. They get a two-cycle ERROR response:
  - cycle 1: HREADYOUT=0, HRESP=1
  - cycle 2: HREADYOUT=1, HRESP=1
  - The write buffer may still commit during these cycles.
  - Implemented as a 3-state FSM: OKAY → ERR1 → ERR2 → OKAY.
- Undefined: HRESP tied 0, HREADYOUT tied 1. Alignment bits below the transfer size are ignored, and HSIZE>=3 is treated as word.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ)
  - HSIZE codes (BYTE, HALF, WORD)
  - HRESP codes (OKAY, ERROR)
  - byte-enable-from-size/offset function
- One sub-module, ahb_sram_wbuf: the one-entry write buffer with capture, commit handshake and read-merge logic.

Test Plan:
- Word write 0xDEADBEEF @0x010, idle, word read @0x010 → sram_we=4'hF in the write data phase; HRDATA=0xDEADBEEF, zero wait states.
- Byte write 0xAB @0x013 over 0x11223344, read word @0x010 → sram_we=4'b1000; HRDATA=0xAB223344.
- Word write 0xCAFEF00D @0x020 immediately followed by read @0x020 → buffer captures the write and the SRAM sees a read; HRDATA=0xCAFEF00D via forwarding; SRAM written in the next free cycle (check cs=1, we=4'hF).
- Half write 0x5566 @0x032 followed by read @0x030 (old word 0xAAAABBBB) → HRDATA=0x5566BBBB; subsequent read after the commit also returns 0x5566BBBB.
- Reset asserted the cycle after the buffered write above → buf_valid=0, sram_we=0, HREADYOUT=1; memory at 0x020 holds its old value.
- With AHB_SRAM_ERR_EN: word read @0x021 → HREADYOUT 0 then 1, HRESP 1 for both cycles, no sram_cs.
- Without AHB_SRAM_ERR_EN: word read @0x021 → OKAY, reads word 0x020.
